// File: rtl/water_tank_level_encoder.sv
// Float-sensor level encoder: sync, debounce and slew-limit the tank level code.
// Optional sensor-consistency check is compiled in with TANK_FAULT_DETECT_EN.
module water_tank_level_encoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned STEP_HOLD       = 25000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_low,
    input  logic       sensor_mid,
    input  logic       sensor_high,
    output logic [1:0] tank_level_status,
    output logic       level_changed,
    output logic       sensor_fault
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = (STEP_HOLD > 1) ? $clog2(STEP_HOLD) : 1;
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(STEP_HOLD - 1);

    typedef enum logic {READY, HOLD} state_t;

    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    stable;
    logic [CW-1:0] deb_cnt [3];
    logic [1:0]    target;
    logic          freeze;
    state_t        state;
    state_t        state_next;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;
    logic [1:0]    status_next;
    logic          pulse_next;

    assign raw = {sensor_high, sensor_mid, sensor_low};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int unsigned i = 0; i < 3; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 3; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (deb_cnt[i] == DEB_LAST) begin
                        stable[i]  <= ~stable[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 1'b1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        target = 2'b00;
        if (stable[2])      target = 2'b11;
        else if (stable[1]) target = 2'b10;
        else if (stable[0]) target = 2'b01;
    end

`ifdef TANK_FAULT_DETECT_EN
    logic inconsistent;
    assign inconsistent = (stable[2] & ~stable[1]) | (stable[2] & ~stable[0]) |
                          (stable[1] & ~stable[0]);
    // Freeze on the live pattern so a bad pattern can never cause even one step.
    assign freeze = inconsistent;

    always_ff @(posedge clk) begin
        if (reset) sensor_fault <= 1'b0;
        else       sensor_fault <= inconsistent;
    end
`else
    assign freeze       = 1'b0;
    assign sensor_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= READY;
            hold_cnt          <= '0;
            tank_level_status <= 2'b00;
            level_changed     <= 1'b0;
        end else begin
            state             <= state_next;
            hold_cnt          <= hold_next;
            tank_level_status <= status_next;
            level_changed     <= pulse_next;
        end
    end

    // HOLD exits on the cycle hold_cnt reaches 1 so steps are exactly STEP_HOLD apart.
    always_comb begin
        state_next = state;
        if (!freeze) begin
            unique case (state)
                READY: if (target != tank_level_status && HOLD_LOAD != '0) state_next = HOLD;
                HOLD:  if (hold_cnt <= HW'(1)) state_next = READY;
                default: state_next = READY;
            endcase
        end
    end

    always_comb begin
        status_next = tank_level_status;
        hold_next   = hold_cnt;
        pulse_next  = 1'b0;
        if (!freeze) begin
            unique case (state)
                READY: begin
                    if (target != tank_level_status) begin
                        status_next = (target > tank_level_status) ? tank_level_status + 2'd1
                                                                   : tank_level_status - 2'd1;
                        pulse_next  = 1'b1;
                        hold_next   = HOLD_LOAD;
                    end
                end
                HOLD: hold_next = (hold_cnt <= HW'(1)) ? '0 : hold_cnt - 1'b1;
                default: hold_next = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_water_tank_level_encoder.sv
// Bench for water_tank_level_encoder: directed scenarios plus randomized
// sensor traffic checked against a run-length / step-age reference model.
module tb_water_tank_level_encoder;
    localparam int D = 4;
    localparam int H = 3;
`ifdef TANK_FAULT_DETECT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sensor_low = 1'b0;
    logic       sensor_mid = 1'b0;
    logic       sensor_high = 1'b0;
    logic [1:0] tank_level_status;
    logic       level_changed;
    logic       sensor_fault;

    int total = 0;
    int bad   = 0;

    // Reference model: sensor index 0=low, 1=mid, 2=high
    bit m_s1 [3];
    bit m_s2 [3];
    bit m_st [3];
    int m_run [3];
    int m_status = 0;
    int m_age = H;
    bit m_pulse = 1'b0;
    bit m_fault = 1'b0;

    water_tank_level_encoder #(.DEBOUNCE_CYCLES(D), .STEP_HOLD(H)) dut (
        .clk              (clk),
        .reset            (reset),
        .sensor_low       (sensor_low),
        .sensor_mid       (sensor_mid),
        .sensor_high      (sensor_high),
        .tank_level_status(tank_level_status),
        .level_changed    (level_changed),
        .sensor_fault     (sensor_fault)
    );

    always #5 clk = ~clk;

    function automatic int level_of(bit h, bit m, bit l);
        if (h) return 3;
        if (m) return 2;
        if (l) return 1;
        return 0;
    endfunction

    task automatic drive(input bit h, input bit m, input bit l);
        sensor_high = h;
        sensor_mid  = m;
        sensor_low  = l;
    endtask

    // Advance one clock and update the model from the values present at the edge.
    task automatic tick();
        bit in_v [3];
        bit rst;
        int tgt;
        int age_now;
        bit incons;
        in_v[0] = sensor_low;
        in_v[1] = sensor_mid;
        in_v[2] = sensor_high;
        rst = reset;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_st[i] = 0; m_run[i] = 0;
            end
            m_status = 0; m_age = H; m_pulse = 0; m_fault = 0;
        end else begin
            tgt    = level_of(m_st[2], m_st[1], m_st[0]);
            incons = (m_st[2] && !m_st[1]) || (m_st[2] && !m_st[0]) || (m_st[1] && !m_st[0]);
            m_pulse = 0;
            if (!(FAULT_EN && incons)) begin
                age_now = m_age + 1;
                if (age_now >= H && tgt != m_status) begin
                    m_status = (tgt > m_status) ? m_status + 1 : m_status - 1;
                    m_pulse  = 1;
                    m_age    = 0;
                end else begin
                    m_age = (age_now > H) ? H : age_now;
                end
            end
            m_fault = FAULT_EN && incons;
            for (int i = 0; i < 3; i++) begin
                if (m_s2[i] != m_st[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= D) begin
                        m_st[i]  = !m_st[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = in_v[i];
            end
        end
        #1;
    endtask

    task automatic clean_reset();
        reset = 1'b1;
        drive(0, 0, 0);
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0);
        repeat (3) tick();
        total++; if (tank_level_status !== 2'b00) begin bad++; $display("FAIL reset_status got=%b exp=00", tank_level_status); end
        total++; if (level_changed !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", level_changed); end
        total++; if (sensor_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", sensor_fault); end
        reset = 1'b0;
        drive(0, 0, 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (tank_level_status !== 2'b00) begin bad++; $display("FAIL midreset_status got=%b exp=00", tank_level_status); end
        repeat (6) tick();
        total++; if (tank_level_status !== 2'b00) begin bad++; $display("FAIL midreset_restart got=%b exp=00", tank_level_status); end
        clean_reset();
    endtask

    task automatic test_low_rise();
        int first = -1;
        int pulses = 0;
        drive(0, 0, 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (first < 0 && tank_level_status != 2'b00) first = k;
            if (level_changed) pulses++;
        end
        total++; if (first != 7) begin bad++; $display("FAIL low_latency got=%0d exp=7", first); end
        total++; if (pulses != 1) begin bad++; $display("FAIL low_pulses got=%0d exp=1", pulses); end
        total++; if (tank_level_status !== 2'b01) begin bad++; $display("FAIL low_status got=%b exp=01", tank_level_status); end
    endtask

    task automatic test_all_rise();
        int edges [$];
        int vals [$];
        drive(1, 1, 1);
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (level_changed) begin edges.push_back(k); vals.push_back(int'(tank_level_status)); end
        end
        total++; if (edges.size() != 2) begin bad++; $display("FAIL rise_pulses got=%0d exp=2", edges.size()); end
        if (edges.size() == 2) begin
            total++; if (edges[0] != 7) begin bad++; $display("FAIL rise_first_edge got=%0d exp=7", edges[0]); end
            total++; if (edges[1] - edges[0] != H) begin bad++; $display("FAIL rise_spacing got=%0d exp=%0d", edges[1] - edges[0], H); end
            total++; if (vals[0] != 2) begin bad++; $display("FAIL rise_step1 got=%0d exp=2", vals[0]); end
        end
        total++; if (tank_level_status !== 2'b11) begin bad++; $display("FAIL rise_final got=%b exp=11", tank_level_status); end
    endtask

    task automatic test_drain();
        int vals [$];
        drive(0, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (level_changed) vals.push_back(int'(tank_level_status));
        end
        total++; if (vals.size() != 3) begin bad++; $display("FAIL drain_pulses got=%0d exp=3", vals.size()); end
        if (vals.size() == 3) begin
            total++; if (vals[0] != 2 || vals[1] != 1 || vals[2] != 0) begin
                bad++; $display("FAIL drain_sequence got=%0d,%0d,%0d exp=2,1,0", vals[0], vals[1], vals[2]);
            end
        end
        total++; if (tank_level_status !== 2'b00) begin bad++; $display("FAIL drain_final got=%b exp=00", tank_level_status); end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        int max_lvl = 0;
        clean_reset();
        drive(0, 0, 1);
        repeat (15) tick();
        drive(0, 1, 1);
        repeat (3) tick();
        drive(0, 0, 1);
        for (int k = 0; k < 15; k++) begin
            tick();
            if (level_changed) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL glitch3_pulses got=%0d exp=0", pulses); end
        total++; if (tank_level_status !== 2'b01) begin bad++; $display("FAIL glitch3_status got=%b exp=01", tank_level_status); end
        pulses = 0;
        drive(0, 1, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (level_changed) pulses++;
            if (int'(tank_level_status) > max_lvl) max_lvl = int'(tank_level_status);
        end
        drive(0, 0, 1);
        for (int k = 0; k < 25; k++) begin
            tick();
            if (level_changed) pulses++;
            if (int'(tank_level_status) > max_lvl) max_lvl = int'(tank_level_status);
        end
        total++; if (max_lvl != 2) begin bad++; $display("FAIL glitch4_peak got=%0d exp=2", max_lvl); end
        total++; if (pulses != 2) begin bad++; $display("FAIL glitch4_pulses got=%0d exp=2", pulses); end
    endtask

`ifdef TANK_FAULT_DETECT_EN
    task automatic test_fault();
        int pulses = 0;
        clean_reset();
        drive(0, 0, 1);
        repeat (15) tick();
        drive(1, 0, 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (level_changed) pulses++;
        end
        total++; if (sensor_fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b exp=1", sensor_fault); end
        total++; if (tank_level_status !== 2'b01) begin bad++; $display("FAIL fault_frozen got=%b exp=01", tank_level_status); end
        total++; if (pulses != 0) begin bad++; $display("FAIL fault_pulses got=%0d exp=0", pulses); end
        pulses = 0;
        drive(1, 1, 1);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (level_changed) pulses++;
        end
        total++; if (sensor_fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", sensor_fault); end
        total++; if (pulses != 2) begin bad++; $display("FAIL fault_resume_pulses got=%0d exp=2", pulses); end
        total++; if (tank_level_status !== 2'b11) begin bad++; $display("FAIL fault_resume_status got=%b exp=11", tank_level_status); end
    endtask
`endif

    task automatic test_random();
        int cyc = 0;
        int len;
        clean_reset();
        while (cyc < 1500) begin
            if ($urandom_range(0, 39) == 0) reset = 1'b1;
            else reset = 1'b0;
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            len = (reset) ? 1 : int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) begin
                tick();
                cyc++;
                total++; if (int'(tank_level_status) != m_status) begin
                    bad++; $display("FAIL rand_status cyc=%0d got=%0d exp=%0d", cyc, tank_level_status, m_status);
                end
                total++; if (level_changed !== m_pulse) begin
                    bad++; $display("FAIL rand_pulse cyc=%0d got=%b exp=%b", cyc, level_changed, m_pulse);
                end
                total++; if (sensor_fault !== m_fault) begin
                    bad++; $display("FAIL rand_fault cyc=%0d got=%b exp=%b", cyc, sensor_fault, m_fault);
                end
            end
            reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_low_rise();
        test_all_rise();
        test_drain();
        test_glitch();
`ifdef TANK_FAULT_DETECT_EN
        test_fault();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
